// File: rtl/tt_wb_bridge_pkg.sv
// Shared command, EXEC opcode and status-bit encodings for the byte-serial Wishbone bridge.
// Pure declarations: no logic, no latency.
package tt_wb_bridge_pkg;

    localparam logic [2:0] CMD_IDLE = 3'd0;
    localparam logic [2:0] CMD_EXEC = 3'd1;
    localparam logic [2:0] CMD_ADR  = 3'd2;
    localparam logic [2:0] CMD_DO   = 3'd3;
    localparam logic [2:0] CMD_DI   = 3'd4;
    localparam logic [2:0] CMD_STAT = 3'd5;

    localparam logic [2:0] EXE_NOP     = 3'd0;
    localparam logic [2:0] EXE_RESET   = 3'd1;
    localparam logic [2:0] EXE_WBSEL   = 3'd2;
    localparam logic [2:0] EXE_AUTOINC = 3'd3;
    localparam logic [2:0] EXE_DISABLE = 3'd4;
    localparam logic [2:0] EXE_ENABLE  = 3'd5;
    localparam logic [2:0] EXE_READ    = 3'd6;
    localparam logic [2:0] EXE_WRITE   = 3'd7;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ACK     = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_TMO     = 3;
    localparam int STAT_CYC     = 4;
    localparam int STAT_AUTOINC = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Index width that stays legal (>= 1 bit) for single-entry counters.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tt_wb_byte_run.sv
// Byte-run index: 0 on the first cycle of a run, +1 (wrapping at NBYTES) while the command repeats.
// Index and write strobe are combinational for the current cycle; no backpressure.
module tt_wb_byte_run
    import tt_wb_bridge_pkg::*;
#(
    parameter  int NBYTES = 4,
    localparam int IW     = idx_width(NBYTES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          match_i,
    input  logic          last_match_i,
    output logic [IW-1:0] idx_o,
    output logic          wr_o
);

    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;

    always_comb begin
        idx_d = '0;
        if (last_match_i && (idx_q != IW'(NBYTES - 1))) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if (match_i) begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_d;
    assign wr_o  = match_i;

endmodule

// File: rtl/tt_wb_bridge_v2.sv
// Byte-serial host to Wishbone classic master with status readback, auto-increment and ACK timeout.
// dout_o/valid_o are registered (one cycle after the command); the host cannot be stalled.
module tt_wb_bridge_v2
    import tt_wb_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 14,
    parameter int ADDRESS_ALIGN  = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0]                cmd_i,
    input  logic [7:0]                din_i,
    output logic [7:0]                dout_o,
    output logic                      valid_o,
    output logic                      wb_CYC,
    output logic                      wb_STB,
    output logic                      wb_WE,
    output logic [ADDRESS_WIDTH-1:0]  wb_ADR,
    output logic [DATA_WIDTH/8-1:0]   wb_SEL,
    output logic [DATA_WIDTH-1:0]     wb_DAT_MOSI,
    input  logic [DATA_WIDTH-1:0]     wb_DAT_MISO,
    input  logic                      wb_ACK,
    input  logic                      wb_ERR
);

    localparam int SW      = DATA_WIDTH / 8;
    localparam int FULL_AW = ADDRESS_WIDTH + ADDRESS_ALIGN;
    localparam int NDB     = DATA_WIDTH / 8;
    localparam int NAB     = (FULL_AW + 7) / 8;
    localparam int ABW     = NAB * 8;
    localparam int AIW     = idx_width(NAB);
    localparam int DIW     = idx_width(NDB);
    localparam int TW      = idx_width(TIMEOUT_CYCLES);

    logic [FULL_AW-1:0]    adr_q, adr_d;
    logic [DATA_WIDTH-1:0] do_q, do_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic                  cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
    logic                  autoinc_q, autoinc_d;
    logic                  ack_q, ack_d, err_q, err_d, tmo_q, tmo_d;
    logic                  valid_q, valid_d;
    logic [7:0]            dout_q, dout_d;
    logic [2:0]            op_q, op_d;
    logic [2:0]            prev_cmd_q;
    logic [TW-1:0]         timer_q, timer_d;
    state_e                state_q, state_d;

    logic [AIW-1:0] adr_idx;
    logic [DIW-1:0] do_idx, di_idx;
    logic           adr_wr, do_wr, di_rd;
    logic [ABW-1:0] adr_ext;
    logic [7:0]     status;

    wire  [2:0] exe_op   = din_i[2:0];
    wire        is_exec  = (cmd_i == CMD_EXEC);
    wire        busy     = (state_q == S_BUSY);
    wire        soft_rst = rst || (is_exec && (exe_op == EXE_RESET));
    wire        is_rw    = is_exec && ((exe_op == EXE_READ) || (exe_op == EXE_WRITE));

    tt_wb_byte_run #(.NBYTES(NAB)) u_adr_run (
        .clk          (clk),
        .rst          (soft_rst),
        .match_i      (cmd_i == CMD_ADR),
        .last_match_i (prev_cmd_q == CMD_ADR),
        .idx_o        (adr_idx),
        .wr_o         (adr_wr)
    );

    tt_wb_byte_run #(.NBYTES(NDB)) u_do_run (
        .clk          (clk),
        .rst          (soft_rst),
        .match_i      (cmd_i == CMD_DO),
        .last_match_i (prev_cmd_q == CMD_DO),
        .idx_o        (do_idx),
        .wr_o         (do_wr)
    );

    tt_wb_byte_run #(.NBYTES(NDB)) u_di_run (
        .clk          (clk),
        .rst          (soft_rst),
        .match_i      (cmd_i == CMD_DI),
        .last_match_i (prev_cmd_q == CMD_DI),
        .idx_o        (di_idx),
        .wr_o         (di_rd)
    );

    always_comb begin
        adr_d     = adr_q;
        do_d      = do_q;
        di_d      = di_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        autoinc_d = autoinc_q;
        ack_d     = ack_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        valid_d   = valid_q;
        op_d      = op_q;
        timer_d   = timer_q;
        state_d   = state_q;
        adr_ext   = ABW'(adr_q);

        status               = '0;
        status[STAT_BUSY]    = busy;
        status[STAT_ACK]     = ack_q;
        status[STAT_ERR]     = err_q;
        status[STAT_TMO]     = tmo_q;
        status[STAT_CYC]     = cyc_q;
        status[STAT_AUTOINC] = autoinc_q;

        if (di_rd) begin
            dout_d = di_q[{di_idx, 3'b000} +: 8];
        end else if (cmd_i == CMD_STAT) begin
            dout_d = status;
        end else begin
            dout_d = di_q[7:0];
        end

        // Register and configuration writes are frozen while a bus cycle is in flight.
        if (!busy) begin
            if (adr_wr) begin
                adr_ext[{adr_idx, 3'b000} +: 8] = din_i;
                adr_d = adr_ext[FULL_AW-1:0];
            end
            if (do_wr) begin
                do_d[{do_idx, 3'b000} +: 8] = din_i;
            end
            if (is_exec) begin
                case (exe_op)
                    EXE_WBSEL:   sel_d     = do_q[SW-1:0];
                    EXE_AUTOINC: autoinc_d = din_i[3];
                    EXE_ENABLE:  cyc_d     = 1'b1;
                    default:     ;
                endcase
            end
        end

        case (state_q)
            S_IDLE: begin
                if (is_rw) begin
                    op_d  = exe_op;
                    ack_d = 1'b0;
                    tmo_d = 1'b0;
                    if (cyc_q) begin
                        stb_d   = 1'b1;
                        we_d    = (exe_op == EXE_WRITE);
                        err_d   = 1'b0;
                        timer_d = '0;
                        state_d = S_BUSY;
                    end else begin
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                timer_d = timer_q + 1'b1;
                if (wb_ACK) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                    if (!we_q) begin
                        di_d = wb_DAT_MISO;
                    end
                    if (autoinc_q) begin
                        adr_d = adr_q + FULL_AW'(1 << ADDRESS_ALIGN);
                    end
                end else if (wb_ERR) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    tmo_d   = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Only a continuously held READ/WRITE keeps the result; a fresh one must pass through S_IDLE.
                if ((cmd_i == CMD_IDLE) ||
                    (is_exec && (prev_cmd_q == CMD_EXEC) && (exe_op == op_q))) begin
                    valid_d = 1'b1;
                end else begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (is_exec && (exe_op == EXE_DISABLE)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            valid_d = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            adr_q      <= '0;
            do_q       <= '0;
            di_q       <= '0;
            sel_q      <= '1;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            autoinc_q  <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            valid_q    <= 1'b0;
            dout_q     <= '0;
            op_q       <= EXE_NOP;
            prev_cmd_q <= CMD_IDLE;
            timer_q    <= '0;
            state_q    <= S_IDLE;
        end else begin
            adr_q      <= adr_d;
            do_q       <= do_d;
            di_q       <= di_d;
            sel_q      <= sel_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            autoinc_q  <= autoinc_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            valid_q    <= valid_d;
            dout_q     <= dout_d;
            op_q       <= op_d;
            prev_cmd_q <= cmd_i;
            timer_q    <= timer_d;
            state_q    <= state_d;
        end
    end

    assign dout_o      = dout_q;
    assign valid_o     = valid_q;
    assign wb_CYC      = cyc_q;
    assign wb_STB      = stb_q;
    assign wb_WE       = we_q;
    assign wb_ADR      = adr_q[FULL_AW-1:ADDRESS_ALIGN];
    assign wb_SEL      = we_q ? sel_q : '0;
    assign wb_DAT_MOSI = do_q;

endmodule

// File: tb/tb_tt_wb_bridge_v2.sv
// Self-checking bench: 32-bit bridge (8-cycle timeout) plus a 16-bit instance.
module tb_tt_wb_bridge_v2;
    import tt_wb_bridge_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  cmd_a;
    logic [7:0]  din_a, dout_a;
    logic        valid_a, cyc_a, stb_a, we_a, ack_a, err_a;
    logic [13:0] adr_a;
    logic [3:0]  sel_a;
    logic [31:0] mosi_a, miso_a;

    logic [2:0]  cmd_b;
    logic [7:0]  din_b, dout_b;
    logic        valid_b, cyc_b, stb_b, we_b, ack_b, err_b;
    logic [13:0] adr_b;
    logic [1:0]  sel_b;
    logic [15:0] mosi_b, miso_b;

    tt_wb_bridge_v2 #(.DATA_WIDTH(32), .ADDRESS_WIDTH(14), .ADDRESS_ALIGN(2), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst), .cmd_i(cmd_a), .din_i(din_a), .dout_o(dout_a), .valid_o(valid_a),
        .wb_CYC(cyc_a), .wb_STB(stb_a), .wb_WE(we_a), .wb_ADR(adr_a), .wb_SEL(sel_a),
        .wb_DAT_MOSI(mosi_a), .wb_DAT_MISO(miso_a), .wb_ACK(ack_a), .wb_ERR(err_a)
    );

    tt_wb_bridge_v2 #(.DATA_WIDTH(16), .ADDRESS_WIDTH(14), .ADDRESS_ALIGN(2), .TIMEOUT_CYCLES(255)) dut_b (
        .clk(clk), .rst(rst), .cmd_i(cmd_b), .din_i(din_b), .dout_o(dout_b), .valid_o(valid_b),
        .wb_CYC(cyc_b), .wb_STB(stb_b), .wb_WE(we_b), .wb_ADR(adr_b), .wb_SEL(sel_b),
        .wb_DAT_MOSI(mosi_b), .wb_DAT_MISO(miso_b), .wb_ACK(ack_b), .wb_ERR(err_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic [2:0] c, input logic [7:0] d);
        cmd_a = c;
        din_a = d;
        @(posedge clk);
        #1;
    endtask

    task automatic tickb(input logic [2:0] c, input logic [7:0] d);
        cmd_b = c;
        din_b = d;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  cmd;
        logic [7:0]  din;
        logic        ack;
        logic        cyc, stb, we, valid;
        logic [7:0]  dout;
        logic [13:0] adr;
        logic [3:0]  sel;
        logic [31:0] mosi;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_b;
        logic [13:0] exp_adr [3];
        logic [15:0] m_addr;
        logic [31:0] m_do, m_di, rnd;
        logic        m_auto, wr, ackb, errb, tmob;
        int          kind, dly, hi;

        // cmd din ack | cyc stb we valid dout adr sel mosi
        tbl[0]  = '{CMD_ADR,  8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h00D, 4'h0, 32'h00000000};
        tbl[1]  = '{CMD_ADR,  8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'h00000000};
        tbl[2]  = '{CMD_DO,   8'hEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'h000000EF};
        tbl[3]  = '{CMD_DO,   8'hBE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'h0000BEEF};
        tbl[4]  = '{CMD_DO,   8'hAD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'h00ADBEEF};
        tbl[5]  = '{CMD_DO,   8'hDE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'hDEADBEEF};
        tbl[6]  = '{CMD_EXEC, 8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'hDEADBEEF};
        tbl[7]  = '{CMD_EXEC, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 14'h48D, 4'hF, 32'hDEADBEEF};
        tbl[8]  = '{CMD_IDLE, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 14'h48D, 4'hF, 32'hDEADBEEF};
        tbl[9]  = '{CMD_IDLE, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 14'h48D, 4'hF, 32'hDEADBEEF};
        tbl[10] = '{CMD_IDLE, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 14'h48D, 4'h0, 32'hDEADBEEF};
        tbl[11] = '{CMD_STAT, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 14'h48D, 4'h0, 32'hDEADBEEF};
        tbl[12] = '{CMD_IDLE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 14'h48D, 4'h0, 32'hDEADBEEF};

        cmd_a = CMD_IDLE; din_a = '0; ack_a = 1'b0; err_a = 1'b0; miso_a = '0;
        cmd_b = CMD_IDLE; din_b = '0; ack_b = 1'b0; err_b = 1'b0; miso_b = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset dout", {24'h0, dout_a}, 32'h0);
        chk("reset valid", {31'h0, valid_a}, 32'h0);
        chk("reset cyc/stb/we", {29'h0, cyc_a, stb_a, we_a}, 32'h0);
        chk("reset adr", {18'h0, adr_a}, 32'h0);
        chk("reset sel", {28'h0, sel_a}, 32'h0);
        chk("reset mosi", mosi_a, 32'h0);
        chk("reset b mosi", {16'h0, mosi_b}, 32'h0);
        rst = 1'b0;

        // Write flow driven from the vector table.
        for (int i = 0; i < 13; i++) begin
            ack_a = tbl[i].ack;
            tick(tbl[i].cmd, tbl[i].din);
            ack_a = 1'b0;
            chk($sformatf("row%0d cyc", i), {31'h0, cyc_a}, {31'h0, tbl[i].cyc});
            chk($sformatf("row%0d stb", i), {31'h0, stb_a}, {31'h0, tbl[i].stb});
            chk($sformatf("row%0d we", i), {31'h0, we_a}, {31'h0, tbl[i].we});
            chk($sformatf("row%0d valid", i), {31'h0, valid_a}, {31'h0, tbl[i].valid});
            chk($sformatf("row%0d dout", i), {24'h0, dout_a}, {24'h0, tbl[i].dout});
            chk($sformatf("row%0d adr", i), {18'h0, adr_a}, {18'h0, tbl[i].adr});
            chk($sformatf("row%0d sel", i), {28'h0, sel_a}, {28'h0, tbl[i].sel});
            chk($sformatf("row%0d mosi", i), mosi_a, tbl[i].mosi);
        end

        // READ then DI byte run with wrap.
        miso_a = 32'hCAFEF00D;
        tick(CMD_EXEC, 8'h06);
        chk("read stb", {31'h0, stb_a}, 32'h1);
        chk("read we/sel", {27'h0, we_a, sel_a}, 32'h0);
        ack_a = 1'b1;
        tick(CMD_IDLE, 8'h00);
        ack_a = 1'b0;
        chk("read valid", {31'h0, valid_a}, 32'h1);
        exp_b = 32'hCAFEF00D;
        for (int j = 0; j < 5; j++) begin
            tick(CMD_DI, 8'h00);
            chk($sformatf("di byte %0d", j), {24'h0, dout_a}, {24'h0, exp_b[(j % 4) * 8 +: 8]});
        end
        chk("di clears valid", {31'h0, valid_a}, 32'h0);

        // Auto-increment across the top of the address space.
        exp_adr[0] = 14'h3FFF; exp_adr[1] = 14'h0000; exp_adr[2] = 14'h0001;
        tick(CMD_EXEC, 8'h0B);
        tick(CMD_ADR, 8'hFC);
        tick(CMD_ADR, 8'hFF);
        for (int k = 0; k < 3; k++) begin
            tick(CMD_EXEC, 8'h06);
            chk($sformatf("autoinc adr %0d", k), {18'h0, adr_a}, {18'h0, exp_adr[k]});
            ack_a = 1'b1;
            tick(CMD_IDLE, 8'h00);
            ack_a = 1'b0;
            tick(3'b110, 8'h00);
        end
        tick(CMD_STAT, 8'h00);
        chk("stat autoinc", {24'h0, dout_a}, 32'h32);

        // Silent slave: STB held for exactly the timeout.
        tick(CMD_EXEC, 8'h03);
        tick(CMD_EXEC, 8'h07);
        hi = 1;
        for (int c = 0; c < 30; c++) begin
            tick(CMD_IDLE, 8'h00);
            if (!stb_a) break;
            hi++;
        end
        chk("timeout stb cycles", hi, 8);
        chk("timeout valid", {31'h0, valid_a}, 32'h1);
        tick(CMD_STAT, 8'h00);
        chk("stat timeout", {24'h0, dout_a}, 32'h18);

        // Error response keeps DI.
        miso_a = 32'h12345678;
        tick(CMD_EXEC, 8'h06);
        err_a = 1'b1;
        tick(CMD_IDLE, 8'h00);
        err_a = 1'b0;
        chk("err valid", {31'h0, valid_a}, 32'h1);
        tick(CMD_STAT, 8'h00);
        chk("stat err", {24'h0, dout_a}, 32'h14);
        tick(CMD_DI, 8'h00);
        chk("err di kept", {24'h0, dout_a}, 32'h0D);

        // WRITE without CYC.
        tick(CMD_EXEC, 8'h04);
        chk("disable cyc", {31'h0, cyc_a}, 32'h0);
        tick(CMD_EXEC, 8'h07);
        chk("no-cyc stb", {31'h0, stb_a}, 32'h0);
        tick(CMD_STAT, 8'h00);
        chk("stat no-cyc", {24'h0, dout_a}, 32'h04);

        // EXEC RESET in the middle of a bus cycle.
        tick(CMD_EXEC, 8'h05);
        tick(CMD_EXEC, 8'h07);
        chk("pre-reset stb", {31'h0, stb_a}, 32'h1);
        tick(CMD_EXEC, 8'h01);
        chk("soft reset cyc/stb", {30'h0, cyc_a, stb_a}, 32'h0);
        ack_a = 1'b1;
        tick(CMD_IDLE, 8'h00);
        ack_a = 1'b0;
        chk("late ack valid", {31'h0, valid_a}, 32'h0);
        tick(CMD_EXEC, 8'h05);
        tick(CMD_EXEC, 8'h07);
        chk("post-reset sel", {28'h0, sel_a}, 32'hF);
        chk("post-reset adr/mosi", {18'h0, adr_a} | mosi_a, 32'h0);
        ack_a = 1'b1;
        tick(CMD_IDLE, 8'h00);
        ack_a = 1'b0;
        tick(3'b110, 8'h00);

        // Randomized transactions against a transaction-level model.
        m_addr = 16'h0000; m_do = 32'h0; m_di = 32'h0;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(1) == 1) begin
                m_addr = 16'($urandom_range(16'hFFFF));
                tick(CMD_ADR, m_addr[7:0]);
                tick(CMD_ADR, m_addr[15:8]);
            end
            if ($urandom_range(1) == 1) begin
                m_do = $urandom;
                for (int b = 0; b < 4; b++) tick(CMD_DO, m_do[b * 8 +: 8]);
            end
            m_auto = 1'($urandom_range(1));
            tick(CMD_EXEC, {4'b0000, m_auto, 3'd3});
            tick(CMD_EXEC, 8'h05);
            wr   = 1'($urandom_range(1));
            kind = $urandom_range(3);
            dly  = $urandom_range(3);
            rnd  = $urandom;
            miso_a = rnd;
            tick(CMD_EXEC, wr ? 8'h07 : 8'h06);
            chk($sformatf("rnd%0d start", t), {28'h0, stb_a, we_a, 2'b00}, {28'h0, 1'b1, wr, 2'b00});
            chk($sformatf("rnd%0d adr", t), {18'h0, adr_a}, {18'h0, m_addr[15:2]});
            chk($sformatf("rnd%0d sel", t), {28'h0, sel_a}, wr ? 32'hF : 32'h0);
            chk($sformatf("rnd%0d mosi", t), mosi_a, m_do);
            hi = 1;
            for (int c = 0; c < 30; c++) begin
                if (kind != 3 && c == dly) begin
                    ack_a = (kind == 0) || (kind == 2);
                    err_a = (kind == 1) || (kind == 2);
                end
                tick(CMD_IDLE, 8'h00);
                ack_a = 1'b0;
                err_a = 1'b0;
                if (!stb_a) break;
                hi++;
            end
            ackb = (kind == 0) || (kind == 2);
            errb = (kind == 1);
            tmob = (kind == 3);
            chk($sformatf("rnd%0d stb cycles", t), hi, tmob ? 8 : dly + 1);
            chk($sformatf("rnd%0d valid", t), {31'h0, valid_a}, 32'h1);
            if (ackb && !wr) m_di = rnd;
            if (ackb && m_auto) m_addr = m_addr + 16'd4;
            tick(CMD_STAT, 8'h00);
            chk($sformatf("rnd%0d stat", t), {24'h0, dout_a},
                {24'h0, 2'b00, m_auto, 1'b1, tmob, errb, ackb, 1'b0});
            for (int b = 0; b < 4; b++) begin
                tick(CMD_DI, 8'h00);
                chk($sformatf("rnd%0d di%0d", t, b), {24'h0, dout_a}, {24'h0, m_di[b * 8 +: 8]});
            end
        end

        // 16-bit instance: DO wrap and byte selects.
        tickb(CMD_DO, 8'h11);
        tickb(CMD_DO, 8'h22);
        tickb(CMD_DO, 8'h33);
        chk("b do wrap", {16'h0, mosi_b}, 32'h2233);
        tickb(CMD_IDLE, 8'h00);
        tickb(CMD_DO, 8'h01);
        tickb(CMD_EXEC, 8'h02);
        tickb(CMD_EXEC, 8'h05);
        tickb(CMD_EXEC, 8'h07);
        chk("b write sel", {30'h0, sel_b}, 32'h1);
        chk("b write stb/we", {30'h0, stb_b, we_b}, 32'h3);
        ack_b = 1'b1;
        tickb(CMD_IDLE, 8'h00);
        ack_b = 1'b0;
        chk("b write valid", {31'h0, valid_b}, 32'h1);
        tickb(3'b110, 8'h00);
        tickb(CMD_EXEC, 8'h06);
        chk("b read sel", {30'h0, sel_b}, 32'h0);
        chk("b read stb", {31'h0, stb_b}, 32'h1);
        ack_b = 1'b1;
        tickb(CMD_IDLE, 8'h00);
        ack_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
